// File: rtl/tdm_demux_4ch_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer.
package tdm_demux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Bit offset of lane idx inside the packed y bus.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  // One-hot write enable for a given lane index.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tdm_demux_4ch_if.sv
// Bus bundle between the upstream serial source / consumers and the demux.
//
// Handshake: a beat on din is consumed on the rising edge where
// din_valid && din_ready are both high; din_ready is combinational and does
// not depend on din_valid. A beat offered while din_ready is low is not
// consumed and causes no side effect.
interface tdm_demux_4ch_if
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 1
);
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [W-1:0]           din;
  logic                   din_valid;
  logic                   din_ready;
  logic                   frame_start;
  logic                   err_clr;
  logic [NUM_LANES*W-1:0] y;
  logic [NUM_LANES-1:0]   y_valid;
  logic                   frame_done;
  logic [SEL_W-1:0]       slot;
  logic                   err_overrun;

  modport master (
    output mode, sel, din, din_valid, frame_start, err_clr,
    input  din_ready, y, y_valid, frame_done, slot, err_overrun
  );

  modport slave (
    input  mode, sel, din, din_valid, frame_start, err_clr,
    output din_ready, y, y_valid, frame_done, slot, err_overrun
  );
endinterface

// File: rtl/tdm_demux_4ch_lane_reg.sv
// One output lane: W-bit held register plus a one-cycle write strobe.
module demux_lane_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o
);

  logic [W-1:0] data_q;
  logic         vld_q;

  // Capture data on load and strobe valid for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= load_i;
      if (load_i) begin
        data_q <= d_i;
      end
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// 1-to-4 registered demux: direct lane select, or TDM slot walk after a
// frame marker. FSM, slot counter and overrun flag live here.
module tdm_demux_4ch
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdm_demux_4ch_if.slave       bus,
  output state_t               state_o
);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     slot_q, slot_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 err_set;
  logic                 xfer;
  logic [NUM_LANES-1:0] wr_en;
  logic [W-1:0]         lane_q   [NUM_LANES];
  logic [NUM_LANES-1:0] lane_vld;

  assign bus.din_ready = ~bus.mode | (state_q == ST_COLLECT);
  assign xfer          = bus.din_valid & bus.din_ready;

  // Next-state, slot, lane write enables and overrun flag.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    wr_en   = '0;
    if (!bus.mode) begin
      // Direct mode parks the framer; leaving a frame open counts as overrun.
      state_d = ST_IDLE;
      slot_d  = '0;
      if (state_q == ST_COLLECT) begin
        err_set = 1'b1;
      end
      if (xfer) begin
        wr_en = lane_onehot(bus.sel);
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) begin
            state_d = ST_COLLECT;
            slot_d  = '0;
          end
        end
        ST_COLLECT: begin
          if (bus.frame_start) begin
            // Restart beats any coincident data beat, which is dropped.
            slot_d  = '0;
            err_set = 1'b1;
          end else if (xfer) begin
            wr_en  = lane_onehot(slot_q);
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end
      endcase
    end
    if (err_set) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_reg #(.W(W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (wr_en[i]),
      .d_i    (bus.din),
      .q_o    (lane_q[i]),
      .vld_o  (lane_vld[i])
    );
  end

  // Pack the lane registers onto the output bus.
  always_comb begin
    bus.y = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      bus.y[lane_lsb(i, W) +: W] = lane_q[i];
    end
  end

  assign bus.y_valid     = lane_vld;
  assign bus.frame_done  = done_q;
  assign bus.slot        = slot_q;
  assign bus.err_overrun = err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch (W=4): directed vector table, async reset
// sequence, then random traffic against a frame-level reference model.
module tb_tdm_demux_4ch;
  import tdm_demux_pkg::*;

  localparam int unsigned W = 4;

  logic   clk;
  logic   rst_n;
  state_t state_o;

  tdm_demux_4ch_if #(.W(W)) bus ();

  tdm_demux_4ch #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit        mode;
    bit [1:0]  sel;
    bit [3:0]  din;
    bit        dv;
    bit        fs;
    bit        clr;
    bit        rdy;
    bit [15:0] y;
    bit [3:0]  yv;
    bit        fd;
    bit [1:0]  slot;
    bit        err;
    bit        col;
  } vec_t;

  vec_t tbl[26];

  // Reference model: four lane values, whether a frame is open, the next
  // position in it, the sticky error and last-edge strobes.
  int       m_lane[4];
  bit       m_in_frame;
  int       m_pos;
  bit       m_err;
  bit [3:0] m_yv;
  bit       m_fd;

  function automatic vec_t mkv(bit mode, bit [1:0] sel, bit [3:0] din, bit dv, bit fs, bit clr,
                               bit rdy, bit [15:0] y, bit [3:0] yv, bit fd, bit [1:0] slot,
                               bit err, bit col);
    vec_t v;
    v.mode = mode; v.sel = sel; v.din = din; v.dv = dv; v.fs = fs; v.clr = clr;
    v.rdy = rdy; v.y = y; v.yv = yv; v.fd = fd; v.slot = slot; v.err = err; v.col = col;
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_lane[i] = 0;
    m_in_frame = 0;
    m_pos      = 0;
    m_err      = 0;
    m_yv       = '0;
    m_fd       = 0;
  endtask

  function automatic bit m_ready(bit mode);
    return !mode || m_in_frame;
  endfunction

  function automatic bit [15:0] m_y();
    bit [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[lane_lsb(i, W) +: W] = m_lane[i][3:0];
    return r;
  endfunction

  task automatic m_step(bit mode, bit [1:0] sel, bit [3:0] din, bit dv, bit fs, bit clr);
    bit set;
    set  = 0;
    m_yv = '0;
    m_fd = 0;
    if (!mode) begin
      if (m_in_frame) set = 1;
      m_in_frame = 0;
      m_pos      = 0;
      if (dv) begin
        m_lane[sel] = din;
        m_yv[sel]   = 1'b1;
      end
    end else if (fs) begin
      if (m_in_frame) set = 1;
      m_in_frame = 1;
      m_pos      = 0;
    end else if (m_in_frame && dv) begin
      m_lane[m_pos] = din;
      m_yv[m_pos]   = 1'b1;
      if (m_pos == 3) begin
        m_fd       = 1;
        m_in_frame = 0;
        m_pos      = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end
    if (set) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  // Scoreboard comparison
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(string tag, bit [15:0] y, bit [3:0] yv, bit fd, bit [1:0] slot,
                             bit err, bit col);
    chk({tag, ".y"},           32'(bus.y), 32'(y));
    chk({tag, ".y_valid"},     32'(bus.y_valid), 32'(yv));
    chk({tag, ".frame_done"},  32'(bus.frame_done), 32'(fd));
    chk({tag, ".slot"},        32'(bus.slot), 32'(slot));
    chk({tag, ".err_overrun"}, 32'(bus.err_overrun), 32'(err));
    chk({tag, ".state"},       32'(state_o == ST_COLLECT), 32'(col));
  endtask

  // Driver
  task automatic drive(bit mode, bit [1:0] sel, bit [3:0] din, bit dv, bit fs, bit clr);
    bus.mode        = mode;
    bus.sel         = sel;
    bus.din         = din;
    bus.din_valid   = dv;
    bus.frame_start = fs;
    bus.err_clr     = clr;
  endtask

  initial begin
    // Directed table: expectations are outputs after the edge; rdy is before it.
    //              mode sel din   dv fs clr  rdy y         yv      fd slot err col
    tbl[0]  = mkv(0, 2, 4'hA, 1, 0, 0,  1, 16'h0A00, 4'b0100, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 4'h0, 0, 0, 0,  1, 16'h0A00, 4'b0000, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 0, 4'h0, 0, 1, 0,  0, 16'h0A00, 4'b0000, 0, 0, 0, 1);
    tbl[3]  = mkv(1, 0, 4'h1, 1, 0, 0,  1, 16'h0A01, 4'b0001, 0, 1, 0, 1);
    tbl[4]  = mkv(1, 0, 4'h2, 1, 0, 0,  1, 16'h0A21, 4'b0010, 0, 2, 0, 1);
    tbl[5]  = mkv(1, 0, 4'h3, 1, 0, 0,  1, 16'h0321, 4'b0100, 0, 3, 0, 1);
    tbl[6]  = mkv(1, 0, 4'h4, 1, 0, 0,  1, 16'h4321, 4'b1000, 1, 0, 0, 0);
    tbl[7]  = mkv(1, 0, 4'h0, 0, 0, 0,  0, 16'h4321, 4'b0000, 0, 0, 0, 0);
    tbl[8]  = mkv(1, 0, 4'h0, 0, 1, 0,  0, 16'h4321, 4'b0000, 0, 0, 0, 1);
    tbl[9]  = mkv(1, 0, 4'h5, 1, 0, 0,  1, 16'h4325, 4'b0001, 0, 1, 0, 1);
    tbl[10] = mkv(1, 0, 4'h6, 1, 0, 0,  1, 16'h4365, 4'b0010, 0, 2, 0, 1);
    tbl[11] = mkv(1, 0, 4'hF, 1, 1, 0,  1, 16'h4365, 4'b0000, 0, 0, 1, 1);
    tbl[12] = mkv(1, 0, 4'h7, 1, 0, 0,  1, 16'h4367, 4'b0001, 0, 1, 1, 1);
    tbl[13] = mkv(1, 0, 4'h0, 0, 0, 1,  1, 16'h4367, 4'b0000, 0, 1, 0, 1);
    tbl[14] = mkv(1, 0, 4'h8, 1, 0, 0,  1, 16'h4387, 4'b0010, 0, 2, 0, 1);
    tbl[15] = mkv(1, 0, 4'h2, 1, 0, 0,  1, 16'h4287, 4'b0100, 0, 3, 0, 1);
    tbl[16] = mkv(1, 0, 4'h3, 1, 0, 0,  1, 16'h3287, 4'b1000, 1, 0, 0, 0);
    tbl[17] = mkv(1, 1, 4'h9, 1, 0, 0,  0, 16'h3287, 4'b0000, 0, 0, 0, 0);
    tbl[18] = mkv(1, 0, 4'h0, 0, 1, 0,  0, 16'h3287, 4'b0000, 0, 0, 0, 1);
    tbl[19] = mkv(1, 0, 4'hB, 1, 0, 0,  1, 16'h328B, 4'b0001, 0, 1, 0, 1);
    tbl[20] = mkv(1, 0, 4'hC, 1, 0, 0,  1, 16'h32CB, 4'b0010, 0, 2, 0, 1);
    tbl[21] = mkv(0, 0, 4'h0, 0, 0, 0,  1, 16'h32CB, 4'b0000, 0, 0, 1, 0);
    tbl[22] = mkv(0, 0, 4'h0, 0, 0, 1,  1, 16'h32CB, 4'b0000, 0, 0, 0, 0);
    tbl[23] = mkv(1, 0, 4'h0, 0, 1, 0,  0, 16'h32CB, 4'b0000, 0, 0, 0, 1);
    tbl[24] = mkv(1, 0, 4'h0, 0, 1, 1,  1, 16'h32CB, 4'b0000, 0, 0, 1, 1);
    tbl[25] = mkv(1, 0, 4'h0, 0, 0, 1,  1, 16'h32CB, 4'b0000, 0, 0, 0, 1);

    // Reset
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 16'h0, 4'b0, 0, 0, 0, 0);
    chk("reset.din_ready", 32'(bus.din_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].mode, tbl[k].sel, tbl[k].din, tbl[k].dv, tbl[k].fs, tbl[k].clr);
      #1;
      chk($sformatf("v%0d.din_ready", k), 32'(bus.din_ready), 32'(tbl[k].rdy));
      m_step(tbl[k].mode, tbl[k].sel, tbl[k].din, tbl[k].dv, tbl[k].fs, tbl[k].clr);
      @(posedge clk);
      #1;
      chk_outputs($sformatf("v%0d", k), tbl[k].y, tbl[k].yv, tbl[k].fd, tbl[k].slot,
                  tbl[k].err, tbl[k].col);
    end

    // Async reset between edges during an open frame.
    drive(1, 0, 4'h0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("async_rst", 16'h0, 4'b0, 0, 0, 0, 0);
    chk("async_rst.din_ready", 32'(bus.din_ready), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    chk_outputs("in_rst", 16'h0, 4'b0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 4'h0, 0, 0, 0);
    #1;
    chk("post_rst.din_ready_m0", 32'(bus.din_ready), 32'd1);
    drive(1, 3, 4'h5, 1, 0, 0);
    #1;
    chk("post_rst.din_ready_m1", 32'(bus.din_ready), 32'd0);
    m_step(1, 3, 4'h5, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_outputs("post_rst", 16'h0, 4'b0, 0, 0, 0, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bit       r_mode, r_dv, r_fs, r_clr;
      bit [1:0] r_sel;
      bit [3:0] r_din;
      r_mode = ($urandom_range(0, 15) != 0);
      r_sel  = 2'($urandom_range(0, 3));
      r_din  = 4'($urandom_range(0, 15));
      r_dv   = ($urandom_range(0, 9) < 7);
      r_fs   = ($urandom_range(0, 9) == 0);
      r_clr  = ($urandom_range(0, 15) == 0);
      drive(r_mode, r_sel, r_din, r_dv, r_fs, r_clr);
      #1;
      chk("rand.din_ready", 32'(bus.din_ready), 32'(m_ready(r_mode)));
      m_step(r_mode, r_sel, r_din, r_dv, r_fs, r_clr);
      @(posedge clk);
      #1;
      chk_outputs("rand", m_y(), m_yv, m_fd, 2'(m_pos), m_err, m_in_frame);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
1-to-4 registered demultiplexer with an optional TDM framing mode. It is the receive-side counterpart of the 4:1 data selector. A W-bit input stream is steered into four held output lanes:
- in direct mode, the lane comes from an explicit 2-bit select;
- in TDM mode, the lane comes from an internal slot counter started by a frame marker.

It sits between a serialised link/selector output and per-channel consumers.

Parameters:
W, 1, data width of the input and of each output lane.

Ports:
clk  input  1  single clock, all state rising-edge.
rst_n  input  1  asynchronous active-low reset.
mode  input  1  0 = direct (lane = sel), 1 = TDM (lane = internal slot).
sel  input  2  destination lane in direct mode; ignored in TDM.
din  input  W  input data.
din_valid  input  1  input beat present.
din_ready  output  1  combinational: 1 when mode=0, or when mode=1 and state=COLLECT.
frame_start  input  1  TDM frame marker, single-cycle pulse; ignored in direct mode.
err_clr  input  1  clears err_overrun.
y  output  4*W  lane i at y[i*W +: W], registered and held between writes.
y_valid  output  4  one-cycle per-lane write strobe.
frame_done  output  1  one-cycle pulse when TDM slot 3 is written.
slot  output  2  current TDM slot index.
err_overrun  output  1  sticky flag: TDM frame restarted or aborted incomplete.

Behaviour:
- Reset (async, rst_n=0): y=0, y_valid=0, frame_done=0, slot=0, err_overrun=0, state=IDLE. Effect is immediate, including mid-frame. din_ready becomes ~mode.
- Transfer occurs on a rising edge when din_valid & din_ready. Latency 1: lane register and y_valid update on that edge. Non-selected lanes hold.
- y_valid and frame_done are low in every cycle without the corresponding event.
- Direct mode (mode=0):
  - every din_valid beat is a transfer: y[sel] <= din, y_valid[sel]=1 next cycle;
  - FSM is held in IDLE with slot=0; frame_start has no effect.
- TDM mode (mode=1) FSM, states IDLE and COLLECT:
  - IDLE: din_ready=0, din_valid is ignored (no error). frame_start -> COLLECT, slot=0.
  - COLLECT, transfer: y[slot] <= din, y_valid[slot]=1, slot <= slot+1 (mod 4).
  - COLLECT, transfer at slot=3: additionally frame_done=1 in the same cycle as y_valid[3]; slot wraps to 0; state -> IDLE.
  - COLLECT, frame_start (with or without din_valid): restart wins; any coincident beat is dropped (not written); slot <= 0; stay in COLLECT; err_overrun <= 1.
  - COLLECT, no event: hold.
- Mode change while in COLLECT: abort to IDLE, slot <= 0, no frame_done, err_overrun <= 1. Lanes already written keep their values.
- err_overrun: set as above; cleared by err_clr on the next edge. A set and a clear in the same cycle resolve to set.
- No arithmetic beyond the 2-bit slot increment, which wraps naturally.

Decomposition:
- Shared package tdm_demux_pkg:
  - NUM_LANES=4 and SEL_W=2;
  - state enum {ST_IDLE, ST_COLLECT};
  - the lane-index-to-slice helper.
- One sub-module: demux_lane_reg, a W-bit register with load enable, async active-low reset, and a registered one-cycle valid strobe. It is instantiated 4x; the FSM, slot counter and error logic live in the top.

Test Plan:
1. Direct mode, W=4: sel=2, din=4'hA, one valid beat -> next cycle y[11:8]=4'hA, y_valid=4'b0100; other lanes 0; din_ready=1 throughout.
2. TDM: frame_start pulse, then beats 4'h1,4'h2,4'h3,4'h4 on consecutive cycles -> y=16'h4321, y_valid walks 0001,0010,0100,1000, frame_done=1 with the 1000 strobe, then state=IDLE, slot=0, din_ready=0.
3. TDM: frame_start, two beats 4'h5,4'h6, then frame_start together with din=4'hF valid -> 4'hF not written, slot=0, err_overrun=1. Lanes 0/1 hold 5/6. A following beat 4'h7 lands in lane 0.
4. TDM IDLE: din_valid with din=4'h9 and no frame_start -> din_ready=0, y unchanged, y_valid=0, err_overrun stays 0.
5. TDM mid-frame (slot=2): drop mode to 0 -> state IDLE, slot=0, err_overrun=1, no frame_done. Then assert err_clr for one cycle -> err_overrun=0.
6. Assert rst_n=0 asynchronously between edges during COLLECT -> all outputs 0 immediately. After release, din_ready=~mode and no strobes fire.
